// File: rtl/pq_pkg.sv
// Shared types, segment constants and helpers for the priority-queue display driver.
// The segment order everywhere is {g,f,e,d,c,b,a}, active-low.
package pq_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_DASH  = 7'b0111111;
   localparam seg_t SEG_I     = 7'b1111001;
   localparam seg_t SEG_S     = 7'b0010010;
   localparam seg_t SEG_A     = 7'b0001000;
   localparam seg_t SEG_R     = 7'b0101111;
   localparam seg_t SEG_D     = 7'b0100001;
   localparam seg_t SEG_F     = 7'b0001110;
   localparam seg_t SEG_E     = 7'b0000110;

   // Flag vector layout: {IDLE, START, ADD, REMOVE, DISPLAY, FULL, EMPTY}
   localparam int FLAG_FULL  = 1;
   localparam int FLAG_EMPTY = 0;

   // Everything captured at a frame boundary; the display only ever reads this copy.
   typedef struct packed {
      logic [3:0] data1;
      logic [3:0] data2;
      logic [2:0] red;
      logic [2:0] green;
      logic [2:0] blue;
      logic [6:0] flags;
   } snap_t;

   // Letter for the automaton state; anything that is not exactly one-hot shows a dash.
   function automatic seg_t state_seg(input logic [6:0] flags);
      seg_t s;
      case (flags)
         7'b1000000: s = SEG_I;
         7'b0100000: s = SEG_S;
         7'b0010000: s = SEG_A;
         7'b0001000: s = SEG_R;
         7'b0000100: s = SEG_D;
         7'b0000010: s = SEG_F;
         7'b0000001: s = SEG_E;
         default:    s = SEG_DASH;
      endcase
      return s;
   endfunction

   // Counter width for a given modulus, never narrower than one bit.
   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_hex
   import pq_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   // Standard hex glyphs, lowercase b and d so they differ from 8 and 0.
   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         4'hF:    seg = 7'b0001110;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/pq_disp_drv.sv
// Display/LED output stage for the priority-queue automaton.
// Scans four active-low seven-segment digits (data1, data2, state letter, blank)
// and drives three PWM LEDs. All inputs are captured once per scan frame.
// Optional build macro PQ_DISP_BLINK_EN: blinks the state digit on FULL/EMPTY.
module pq_disp_drv
   import pq_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int PWM_DIV      = 16,
   parameter int BLINK_FRAMES = 250
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data1,
   input  logic [3:0] data2,
   input  logic [2:0] red,
   input  logic [2:0] green,
   input  logic [2:0] blue,
   input  logic       sigIDLE,
   input  logic       sigSTART,
   input  logic       sigADD,
   input  logic       sigREMOVE,
   input  logic       sigDISPLAY,
   input  logic       sigFULL,
   input  logic       sigEMPTY,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b
);

   localparam int RW = cnt_width(REFRESH_DIV);
   localparam int PW = cnt_width(PWM_DIV);

   logic [RW-1:0] refresh_cnt_r;
   logic [1:0]    digit_idx_r;
   logic [PW-1:0] pwm_div_r;
   logic [2:0]    pwm_cnt_r;
   snap_t         snap_r;

   logic          tick_s;
   logic          frame_s;
   logic          pwm_step_s;
   logic          state_blank_s;
   logic [3:0]    nibble_s;
   seg_t          hex_seg_s;
   seg_t          digit_seg_s;
   logic [3:0]    an_next_s;

   assign tick_s     = (refresh_cnt_r == RW'(REFRESH_DIV - 1));
   assign frame_s    = tick_s && (digit_idx_r == 2'd3);
   assign pwm_step_s = (pwm_div_r == PW'(PWM_DIV - 1));

   // Digit-slot timer: wraps on tick.
   always_ff @(posedge clk) begin
      if (!rst) begin
         refresh_cnt_r <= '0;
      end else if (tick_s) begin
         refresh_cnt_r <= '0;
      end else begin
         refresh_cnt_r <= refresh_cnt_r + RW'(1);
      end
   end

   // Digit index 3 -> 0 -> 1 -> 2 -> 3; starts at 3 so the first tick opens a frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         digit_idx_r <= 2'd3;
      end else if (tick_s) begin
         digit_idx_r <= digit_idx_r + 2'd1;
      end else begin
         digit_idx_r <= digit_idx_r;
      end
   end

   // Capture all inputs at the frame boundary so a frame never mixes old and new values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         snap_r <= '0;
      end else if (frame_s) begin
         snap_r <= '{data1: data1, data2: data2, red: red, green: green, blue: blue,
                     flags: {sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY, sigFULL, sigEMPTY}};
      end else begin
         snap_r <= snap_r;
      end
   end

   // PWM prescaler: one step of the duty counter every PWM_DIV cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pwm_div_r <= '0;
      end else if (pwm_step_s) begin
         pwm_div_r <= '0;
      end else begin
         pwm_div_r <= pwm_div_r + PW'(1);
      end
   end

   // 3-bit duty counter, free-running 0..7.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pwm_cnt_r <= 3'd0;
      end else if (pwm_step_s) begin
         pwm_cnt_r <= pwm_cnt_r + 3'd1;
      end else begin
         pwm_cnt_r <= pwm_cnt_r;
      end
   end

`ifdef PQ_DISP_BLINK_EN
   localparam int FW = cnt_width(BLINK_FRAMES);

   logic [FW-1:0] frame_cnt_r;
   logic          blink_ph_r;

   // Count frame boundaries; flip the blink phase every BLINK_FRAMES of them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_cnt_r <= '0;
         blink_ph_r  <= 1'b0;
      end else if (frame_s) begin
         if (frame_cnt_r == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt_r <= '0;
            blink_ph_r  <= ~blink_ph_r;
         end else begin
            frame_cnt_r <= frame_cnt_r + FW'(1);
            blink_ph_r  <= blink_ph_r;
         end
      end else begin
         frame_cnt_r <= frame_cnt_r;
         blink_ph_r  <= blink_ph_r;
      end
   end

   assign state_blank_s = blink_ph_r & (snap_r.flags[FLAG_FULL] | snap_r.flags[FLAG_EMPTY]);
`else
   assign state_blank_s = 1'b0;
`endif

   // Only digits 0 and 1 carry hex, so the single decoder just needs the right nibble.
   always_comb begin
      nibble_s = snap_r.data2;
      if (digit_idx_r == 2'd0) begin
         nibble_s = snap_r.data1;
      end else begin
         nibble_s = snap_r.data2;
      end
   end

   seg7_hex u_hex (
      .nibble (nibble_s),
      .seg    (hex_seg_s)
   );

   // Select segment pattern and digit enable for the current slot.
   always_comb begin
      digit_seg_s = SEG_BLANK;
      an_next_s   = 4'b1111;
      case (digit_idx_r)
         2'd0: begin
            digit_seg_s = hex_seg_s;
            an_next_s   = 4'b1110;
         end
         2'd1: begin
            digit_seg_s = hex_seg_s;
            an_next_s   = 4'b1101;
         end
         2'd2: begin
            if (state_blank_s) begin
               digit_seg_s = SEG_BLANK;
            end else begin
               digit_seg_s = state_seg(snap_r.flags);
            end
            an_next_s = 4'b1011;
         end
         2'd3: begin
            digit_seg_s = SEG_BLANK;
            an_next_s   = 4'b0111;
         end
         default: begin
            digit_seg_s = SEG_BLANK;
            an_next_s   = 4'b1111;
         end
      endcase
   end

   // Register every output pin; reset turns the display and LEDs fully off.
   always_ff @(posedge clk) begin
      if (!rst) begin
         an    <= 4'b1111;
         seg   <= SEG_BLANK;
         dp    <= 1'b1;
         led_r <= 1'b0;
         led_g <= 1'b0;
         led_b <= 1'b0;
      end else begin
         an    <= an_next_s;
         seg   <= digit_seg_s;
         dp    <= 1'b1;
         led_r <= (pwm_cnt_r < snap_r.red);
         led_g <= (pwm_cnt_r < snap_r.green);
         led_b <= (pwm_cnt_r < snap_r.blue);
      end
   end

endmodule

// File: tb/tb_pq_disp_drv.sv
// Directed, table-driven bench for pq_disp_drv (REFRESH_DIV=4, PWM_DIV=1, BLINK_FRAMES=2).
// Each table row is one scan frame: inputs applied just before the frame boundary,
// then the four digit slots and the LED duty over 8 cycles are compared.
module tb_pq_disp_drv;

   localparam int RD = 4;
   localparam int BF = 2;

   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;

   typedef struct {
      logic       drive;
      logic [3:0] d1;
      logic [3:0] d2;
      logic [6:0] flags;
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
      logic       mid_en;
      logic [3:0] mid_d1;
      logic [6:0] e0;
      logic [6:0] e1;
      logic [6:0] e2;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] data1 = 4'h0;
   logic [3:0] data2 = 4'h0;
   logic [2:0] red = 3'd0;
   logic [2:0] green = 3'd0;
   logic [2:0] blue = 3'd0;
   logic [6:0] flags = 7'b0000000;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       led_r;
   logic       led_g;
   logic       led_b;

   int n_cmp = 0;
   int n_bad = 0;
   int frame_no = 0;
   logic [6:0] m_flags = 7'b0000000;
   logic [2:0] m_r = 3'd0;
   logic [2:0] m_g = 3'd0;
   logic [2:0] m_b = 3'd0;
   vec_t vecs [14];

   always #5 clk = ~clk;

   pq_disp_drv #(.REFRESH_DIV(RD), .PWM_DIV(1), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .rst        (rst),
      .data1      (data1),
      .data2      (data2),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .sigIDLE    (flags[6]),
      .sigSTART   (flags[5]),
      .sigADD     (flags[4]),
      .sigREMOVE  (flags[3]),
      .sigDISPLAY (flags[2]),
      .sigFULL    (flags[1]),
      .sigEMPTY   (flags[0]),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .led_r      (led_r),
      .led_g      (led_g),
      .led_b      (led_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Hold reset for n cycles, release, and step to just before the first frame boundary.
   task automatic do_reset(input int n);
      rst = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("rst_an", {28'd0, an}, {28'd0, 4'b1111});
         chk("rst_seg", {25'd0, seg}, {25'd0, BLANK});
         chk("rst_dp", {31'd0, dp}, 32'd1);
         chk("rst_leds", {29'd0, led_r, led_g, led_b}, 32'd0);
      end
      rst = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("post_rst_an", {28'd0, an}, {28'd0, 4'b0111});
         chk("post_rst_seg", {25'd0, seg}, {25'd0, BLANK});
         chk("post_rst_leds", {29'd0, led_r, led_g, led_b}, 32'd0);
      end
      frame_no = 0;
   endtask

   // Entry/exit: at the negedge just before a frame-boundary clock edge.
   task automatic do_frame(input vec_t v);
      logic [6:0] exp_seg [4];
      logic [3:0] exp_an [4];
      int cr, cg, cb;
      exp_an[0] = 4'b1110;
      exp_an[1] = 4'b1101;
      exp_an[2] = 4'b1011;
      exp_an[3] = 4'b0111;
      cr = 0;
      cg = 0;
      cb = 0;
      if (v.drive) begin
         data1 = v.d1;
         data2 = v.d2;
         flags = v.flags;
         red   = v.r;
         green = v.g;
         blue  = v.b;
         m_flags = v.flags;
         m_r = v.r;
         m_g = v.g;
         m_b = v.b;
      end
      frame_no++;
      exp_seg[0] = v.e0;
      exp_seg[1] = v.e1;
      exp_seg[2] = v.e2;
      exp_seg[3] = BLANK;
`ifdef PQ_DISP_BLINK_EN
      if ((((frame_no / BF) % 2) == 1) && (m_flags[1] || m_flags[0])) begin
         exp_seg[2] = BLANK;
      end
`endif
      for (int j = 0; j < 4 * RD; j++) begin
         @(negedge clk);
         if (j == 0) begin
            chk("pre_frame_an", {28'd0, an}, {28'd0, 4'b0111});
            if (v.mid_en) begin
               data1 = v.mid_d1;
            end
         end
         if ((j % RD) == 1) begin
            chk($sformatf("f%0d_an%0d", frame_no, j / RD), {28'd0, an}, {28'd0, exp_an[j / RD]});
            chk($sformatf("f%0d_seg%0d", frame_no, j / RD), {25'd0, seg}, {25'd0, exp_seg[j / RD]});
            chk("dp", {31'd0, dp}, 32'd1);
         end
         if (j >= 2 && j <= 9) begin
            cr += int'(led_r);
            cg += int'(led_g);
            cb += int'(led_b);
         end
      end
      chk($sformatf("f%0d_led_r_duty", frame_no), cr, {29'd0, m_r});
      chk($sformatf("f%0d_led_g_duty", frame_no), cg, {29'd0, m_g});
      chk($sformatf("f%0d_led_b_duty", frame_no), cb, {29'd0, m_b});
   endtask

   initial begin
      //              drv  d1     d2     flags       r     g     b    mid   mid_d1 e0          e1          e2
      vecs[0]  = '{1'b1, 4'hA, 4'h0, 7'b0010000, 3'd3, 3'd0, 3'd7, 1'b0, 4'h0, 7'b0001000, 7'b1000000, 7'b0001000};
      vecs[1]  = '{1'b1, 4'hA, 4'h0, 7'b0010000, 3'd3, 3'd0, 3'd7, 1'b1, 4'h8, 7'b0001000, 7'b1000000, 7'b0001000};
      vecs[2]  = '{1'b0, 4'h0, 4'h0, 7'b0000000, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 7'b0000000, 7'b1000000, 7'b0001000};
      vecs[3]  = '{1'b1, 4'h1, 4'h2, 7'b0010010, 3'd7, 3'd7, 3'd0, 1'b0, 4'h0, 7'b1111001, 7'b0100100, DASH};
      vecs[4]  = '{1'b1, 4'hF, 4'hE, 7'b0000000, 3'd0, 3'd1, 3'd2, 1'b0, 4'h0, 7'b0001110, 7'b0000110, DASH};
      vecs[5]  = '{1'b1, 4'h3, 4'h4, 7'b1000000, 3'd5, 3'd6, 3'd4, 1'b0, 4'h0, 7'b0110000, 7'b0011001, 7'b1111001};
      vecs[6]  = '{1'b1, 4'h5, 4'h6, 7'b0100000, 3'd1, 3'd2, 3'd3, 1'b0, 4'h0, 7'b0010010, 7'b0000010, 7'b0010010};
      vecs[7]  = '{1'b1, 4'h7, 4'h9, 7'b0001000, 3'd6, 3'd5, 3'd4, 1'b0, 4'h0, 7'b1111000, 7'b0010000, 7'b0101111};
      vecs[8]  = '{1'b1, 4'hB, 4'hC, 7'b0000100, 3'd2, 3'd4, 3'd6, 1'b0, 4'h0, 7'b0000011, 7'b1000110, 7'b0100001};
      vecs[9]  = '{1'b1, 4'hD, 4'h5, 7'b0000010, 3'd4, 3'd0, 3'd1, 1'b0, 4'h0, 7'b0100001, 7'b0010010, 7'b0001110};
      vecs[10] = '{1'b1, 4'h0, 4'h1, 7'b0000010, 3'd7, 3'd3, 3'd5, 1'b0, 4'h0, 7'b1000000, 7'b1111001, 7'b0001110};
      vecs[11] = '{1'b0, 4'h0, 4'h0, 7'b0000000, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 7'b1000000, 7'b1111001, 7'b0001110};
      vecs[12] = '{1'b1, 4'h2, 4'h3, 7'b0000001, 3'd0, 3'd7, 3'd0, 1'b0, 4'h0, 7'b0100100, 7'b0110000, 7'b0000110};
      vecs[13] = '{1'b1, 4'h4, 4'h5, 7'b1000000, 3'd1, 3'd0, 3'd6, 1'b0, 4'h0, 7'b0011001, 7'b0010010, 7'b1111001};

      do_reset(3);
      for (int i = 0; i < 14; i++) begin
         do_frame(vecs[i]);
      end

      // Reset in the middle of a frame must blank everything on the next edge.
      repeat (6) @(negedge clk);
      do_reset(2);
      do_frame(vecs[0]);
      do_frame(vecs[3]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
